data_in_stream: RTL and testbench

Parametrised front-end stage that turns one of N raw converter streams (high-speed ADC channels, ADC 2308, simulated source) into a single 32-bit Avalon-ST-style sample stream for the lock-in core. It selects a channel and converts offset-binary to two's complement when configured. It block-averages 2^k samples per output and marks frame boundaries every `frame_len` outputs. It sits between the acquisition drivers and the processing chain, replacing the fixed per-source valid/data wiring.

---
 rtl/data_in_stream.sv | 163 ++++++++++++++++
 tb/tb_data_in_stream.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_in_stream.sv
// data_in_stream: selects one of N_CH converter streams, optionally converts
// offset binary to two's complement, block-averages 2^k samples per output and
// flags the last output of each frame.
// Optional feature: define DATA_IN_OVR_COUNT_EN to build the over-range event
// counter; without it ovr_count is tied to 0 and ch_otr is unused.
module data_in_stream #(
  parameter int N_CH          = 4,
  parameter int W_IN          = 14,
  parameter int W_OUT         = 32,
  parameter int MAX_LOG2_AVG  = 8,
  parameter int OFFSET_BINARY = 1,
  localparam int SEL_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [SEL_W-1:0]       sel_ch,
  input  logic [3:0]             log2_avg,
  input  logic [31:0]            frame_len,
  input  logic [N_CH*W_IN-1:0]   ch_data,
  input  logic [N_CH-1:0]        ch_valid,
  input  logic [N_CH-1:0]        ch_otr,
  output logic [W_OUT-1:0]       data_out,
  output logic                   data_valid,
  output logic                   frame_end,
  output logic                   busy,
  output logic [31:0]            ovr_count
);

  localparam int ACC_W = W_IN + MAX_LOG2_AVG;   // sum of 2^MAX samples never overflows
  localparam int CNT_W = MAX_LOG2_AVG + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                   state_q;
  logic                     busy_q;
  logic [SEL_W-1:0]         sel_q;
  logic [3:0]               k_q;
  logic [31:0]              flen_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [31:0]              fcnt_q;
  logic [W_OUT-1:0]         dout_q;
  logic                     dv_q;
  logic                     fe_q;

  logic [3:0]               k_clamp;
  logic [W_IN-1:0]          raw_s;
  logic signed [W_IN-1:0]   samp_s;
  logic signed [ACC_W-1:0]  samp_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  avg_full;
  logic signed [W_IN-1:0]   avg_w;
  logic signed [W_OUT-1:0]  avg_ext;
  logic [CNT_W-1:0]         blk_last;
  logic                     start;
  logic                     accept;
  logic                     blk_done;

  // Datapath for the currently latched channel: decode, extend, sum, mean.
  always_comb begin
    k_clamp  = (log2_avg > 4'(MAX_LOG2_AVG)) ? 4'(MAX_LOG2_AVG) : log2_avg;
    raw_s    = ch_data[int'(sel_q)*W_IN +: W_IN];
    samp_s   = (OFFSET_BINARY != 0) ? {~raw_s[W_IN-1], raw_s[W_IN-2:0]} : raw_s;
    samp_ext = samp_s;
    acc_sum  = acc_q + samp_ext;
    // Mean of a block always fits back into W_IN bits.
    avg_full = acc_sum >>> k_q;
    avg_w    = avg_full[W_IN-1:0];
    avg_ext  = avg_w;
    blk_last = (CNT_W'(1) << k_q) - CNT_W'(1);
    start    = (state_q == S_IDLE) && enable;
    // Stop wins: a sample arriving as enable falls is dropped.
    accept   = (state_q == S_RUN) && enable && ch_valid[sel_q];
    blk_done = accept && (cnt_q == blk_last);
  end

  // Control FSM, accumulator, frame counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      sel_q   <= '0;
      k_q     <= '0;
      flen_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      fe_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            sel_q   <= sel_ch;
            k_q     <= k_clamp;
            flen_q  <= frame_len;
            acc_q   <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
          end
        end
        S_RUN: begin
          if (!enable) begin
            // Partial block is thrown away.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
          end else if (blk_done) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            dout_q <= W_OUT'(avg_ext);
            dv_q   <= 1'b1;
            // frame_len == 0 never matches: continuous mode.
            if ((flen_q != 32'd0) && (fcnt_q == flen_q - 32'd1)) begin
              fe_q   <= 1'b1;
              fcnt_q <= '0;
            end else begin
              fcnt_q <= fcnt_q + 32'd1;
            end
          end else if (accept) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign frame_end  = fe_q;
  assign busy       = busy_q;

`ifdef DATA_IN_OVR_COUNT_EN
  logic [31:0] ovr_q;

  // Saturating count of accepted over-range samples; cleared on each start.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q <= '0;
    end else if (start) begin
      ovr_q <= '0;
    end else if (accept && ch_otr[sel_q] && (ovr_q != 32'hFFFF_FFFF)) begin
      ovr_q <= ovr_q + 32'd1;
    end
  end

  assign ovr_count = ovr_q;
`else
  logic unused_otr;
  assign unused_otr = ^{ch_otr, start};
  assign ovr_count  = '0;
`endif

endmodule

// File: tb/tb_data_in_stream.sv
// Randomized and directed bench for data_in_stream against a queue-based
// reference model of the averaging / framing behaviour.
module tb_data_in_stream;
  localparam int N_CH = 4;
  localparam int W_IN = 14;
  localparam int OB   = 1;

  logic                 clk;
  logic                 reset;
  logic                 enable;
  logic [1:0]           sel_ch;
  logic [3:0]           log2_avg;
  logic [31:0]          frame_len;
  logic [N_CH*W_IN-1:0] ch_data;
  logic [N_CH-1:0]      ch_valid;
  logic [N_CH-1:0]      ch_otr;
  logic [31:0]          data_out;
  logic                 data_valid;
  logic                 frame_end;
  logic                 busy;
  logic [31:0]          ovr_count;

  data_in_stream dut (
    .clk(clk), .reset(reset), .enable(enable), .sel_ch(sel_ch),
    .log2_avg(log2_avg), .frame_len(frame_len), .ch_data(ch_data),
    .ch_valid(ch_valid), .ch_otr(ch_otr), .data_out(data_out),
    .data_valid(data_valid), .frame_end(frame_end), .busy(busy),
    .ovr_count(ovr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_run;
  int          m_sel;
  int          m_k;
  longint      m_flen;
  longint      m_outs;
  int          m_blk[$];
  logic [31:0] m_dout;
  bit          m_dv, m_fe;
  longint      m_ovr;

  function automatic int dec(input logic [13:0] raw);
    int u;
    u = (OB != 0) ? int'(raw ^ 14'h2000) : int'(raw);
    if (u >= 8192) u -= 16384;
    return u;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_run = 0; m_blk.delete(); m_dout = '0; m_dv = 0; m_fe = 0;
      m_ovr = 0; m_outs = 0;
    end else begin
      m_dv = 0; m_fe = 0;
      if (!m_run) begin
        if (enable) begin
          m_run  = 1;
          m_sel  = int'(sel_ch);
          m_k    = (log2_avg > 8) ? 8 : int'(log2_avg);
          m_flen = longint'(frame_len);
          m_blk.delete();
          m_outs = 0;
          m_ovr  = 0;
        end
      end else if (!enable) begin
        m_run = 0;
        m_blk.delete();
      end else if (ch_valid[m_sel]) begin
        m_blk.push_back(dec(ch_data[m_sel*W_IN +: W_IN]));
        if (ch_otr[m_sel] && m_ovr < 64'hFFFF_FFFF) m_ovr++;
        if (m_blk.size() == (1 << m_k)) begin
          longint s, n, mean;
          s = 0;
          foreach (m_blk[i]) s += m_blk[i];
          n = longint'(1) << m_k;
          mean = s / n;
          if ((s % n != 0) && (s < 0)) mean -= 1;   // floor, not truncation
          m_dout = 32'(mean);
          m_dv   = 1;
          m_outs++;
          m_fe   = (m_flen != 0) && (m_outs % m_flen == 0);
          m_blk.delete();
        end
      end
    end
  endtask

  // One clock: update model with the inputs in force, clock, compare.
  task automatic cyc();
    logic [31:0] exp_ovr;
    model_step();
    @(posedge clk);
    #1;
`ifdef DATA_IN_OVR_COUNT_EN
    exp_ovr = 32'(m_ovr);
`else
    exp_ovr = '0;
`endif
    chk("data_valid", data_valid, m_dv);
    chk("frame_end", frame_end, m_fe);
    chk("busy", busy, m_run);
    chk("data_out", data_out, m_dout);
    chk("ovr_count", ovr_count, exp_ovr);
  endtask

  task automatic put(input int c, input logic [13:0] raw, input bit otr);
    ch_valid = '0;
    ch_otr   = '0;
    ch_data[c*W_IN +: W_IN] = raw;
    ch_valid[c] = 1'b1;
    ch_otr[c]   = otr;
    cyc();
    ch_valid = '0;
    ch_otr   = '0;
  endtask

  // Drive a two's-complement value, encoded as the converter would send it.
  task automatic put_tc(input int c, input int v);
    logic [13:0] r;
    r = v[13:0];
    if (OB != 0) r = r ^ 14'h2000;
    put(c, r, 1'b0);
  endtask

  task automatic start(input int sel, input int k, input int flen);
    sel_ch    = 2'(sel);
    log2_avg  = 4'(k);
    frame_len = 32'(flen);
    enable    = 1'b1;
    ch_valid  = '0;
    cyc();
  endtask

  task automatic stop();
    enable   = 1'b0;
    ch_valid = '0;
    cyc();
  endtask

  task automatic rand_cycle(input int drop_pct);
    ch_data  = 56'({$urandom(), $urandom()});
    ch_valid = 4'($urandom());
    ch_otr   = 4'($urandom());
    if ($urandom_range(99) < drop_pct) enable = 1'b0;
    else enable = 1'b1;
    cyc();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sel_ch = '0; log2_avg = '0; frame_len = '0;
    ch_data = '0; ch_valid = '0; ch_otr = '0;
    cyc(); cyc();
    chk("reset_dout", data_out, 32'd0);
    reset = 1'b0;
    cyc();

    // Pass-through on channel 2, other channels' strobes ignored.
    start(2, 0, 0);
    put(2, 14'h2000, 1'b0); chk("pt_0", data_out, 32'd0);
    put(2, 14'h3FFF, 1'b0); chk("pt_max", data_out, 32'd8191);
    put(0, 14'h1234, 1'b0); chk("pt_ign_ch0", data_valid, 1'b0);
    put(2, 14'h0000, 1'b0); chk("pt_min", data_out, 32'hFFFF_E000);
    put(1, 14'h0001, 1'b0);
    put(3, 14'h3FFF, 1'b0); chk("pt_ign_ch3", data_valid, 1'b0);
    stop();

    // Averaging, k=2: floor of the mean.
    start(1, 2, 0);
    put_tc(1, 3); put_tc(1, 4); put_tc(1, -1); put_tc(1, 0);
    chk("avg_pos", data_out, 32'd1);
    put_tc(1, -1); put_tc(1, -1); put_tc(1, -1); put_tc(1, -2);
    chk("avg_neg", data_out, 32'hFFFF_FFFE);
    stop();

    // Framing: 3, 0 (continuous), 1.
    start(0, 0, 3);
    for (int i = 0; i < 7; i++) put_tc(0, i);
    stop();
    start(0, 0, 0);
    for (int i = 0; i < 7; i++) put_tc(0, i);
    stop();
    start(0, 0, 1);
    for (int i = 0; i < 3; i++) put_tc(0, -i);
    stop();

    // Stop mid-average, then restart.
    start(3, 3, 0);
    for (int i = 0; i < 5; i++) put_tc(3, 1000);
    stop();
    start(3, 3, 0);
    for (int i = 0; i < 8; i++) put_tc(3, -7);
    chk("restart_avg", data_out, 32'hFFFF_FFF9);
    // Completing sample arriving with enable low is dropped.
    start(3, 0, 0);
    enable = 1'b0;
    put_tc(3, 55);
    chk("stop_wins", data_valid, 1'b0);

    // Clamp and latch: k=12 becomes 8; config changes mid-run ignored.
    start(1, 12, 2);
    for (int i = 0; i < 520; i++) begin
      if (i == 100) begin sel_ch = 2'd0; log2_avg = 4'd0; frame_len = 32'd1; end
      ch_data  = 56'({$urandom(), $urandom()});
      ch_valid = 4'b0010;
      cyc();
    end
    stop();

    // Reset mid-frame.
    start(2, 1, 4);
    put_tc(2, 9);
    reset = 1'b1;
    put_tc(2, 9);
    chk("rst_mid_dv", data_valid, 1'b0);
    reset = 1'b0;
    cyc();

    // Over-range events: 10 samples, 4 flagged, then restart clears.
    start(2, 1, 0);
    for (int i = 0; i < 10; i++) put(2, 14'(i * 97), (i % 3) == 0);
    stop();
    start(2, 1, 0);
    stop();

    // Random configurations and traffic.
    for (int r = 0; r < 8; r++) begin
      start($urandom_range(3), ($urandom_range(3) == 0) ? $urandom_range(15) : $urandom_range(3),
            $urandom_range(4));
      for (int i = 0; i < 150; i++) rand_cycle(2);
      stop();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
